// File: rtl/aes_reg_status_pkg.sv
// aes_reg_status_pkg: shared types and helpers for the register-group status tracker
package aes_reg_status_pkg;

    typedef struct packed {
        logic is_new;
        logic clean;
        logic stale;
    } group_status_t;

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned lim);
        return (v >= lim) ? v : v + 1;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/aes_reg_status_group.sv
// aes_reg_status_group: write-completeness, cleanliness and stale-partial tracking of one register group
module aes_reg_status_group
    import aes_reg_status_pkg::*;
#(
    parameter int unsigned Width         = 4,
    parameter int unsigned TimeoutCycles = 16,
    parameter bit          AutoArm       = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] we_i,
    input  logic             use_i,
    input  logic             clear_i,
    input  logic             arm_i,
    output group_status_t    status_o,
    output logic             new_pulse_o
);

    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    logic [Width-1:0] we_q, we_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             armed_q, armed_d, new_q, new_d, clean_q, clean_d, stale_q, stale_d;
    logic             wr, kill, armed_wr, all_w, none_w, partial;

    // next-state of the group: clear beats use beats an armed (restarting) write beats accumulation
    always_comb begin
        wr       = |we_i;
        kill     = clear_i | use_i;
        armed_wr = armed_q & wr;
        we_d     = kill ? '0 : armed_wr ? we_i : (we_q | we_i);
        armed_d  = clear_i ? 1'b0 : use_i ? AutoArm : armed_wr ? 1'b0 : (armed_q | arm_i);
        all_w    = &we_d;
        none_w   = ~|we_d;
        partial  = ~all_w & ~none_w;
        new_d    = ~kill & all_w;
        clean_d  = clear_i ? 1'b0 : all_w ? 1'b1 : none_w ? clean_q : 1'b0;
        cnt_d    = (~partial | wr | kill) ? '0 : CntW'(sat_inc(32'(cnt_q), TimeoutCycles));
        stale_d  = partial & (cnt_d == CntW'(TimeoutCycles)) & (TimeoutCycles != 0);
    end

    // state registers, wiped asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            new_q   <= 1'b0;
            clean_q <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            new_q   <= new_d;
            clean_q <= clean_d;
            stale_q <= stale_d;
        end
    end

    assign status_o    = '{is_new: new_q, clean: clean_q, stale: stale_q};
    assign new_pulse_o = new_d & ~new_q;

endmodule

// File: rtl/aes_reg_status_multi.sv
// aes_reg_status_multi: per-group write tracking for several multi-word registers plus aggregate status
module aes_reg_status_multi
    import aes_reg_status_pkg::*;
#(
    parameter int unsigned NumGroups     = 3,
    parameter int unsigned Width         = 4,
    parameter int unsigned TimeoutCycles = 16,
    parameter bit          AutoArm       = 1'b0,
    localparam int unsigned PendW        = $clog2(NumGroups + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumGroups*Width-1:0] we_i,
    input  logic [NumGroups-1:0]       use_i,
    input  logic [NumGroups-1:0]       clear_i,
    input  logic [NumGroups-1:0]       arm_i,
    output logic [NumGroups-1:0]       new_o,
    output logic [NumGroups-1:0]       new_pulse_o,
    output logic [NumGroups-1:0]       clean_o,
    output logic [NumGroups-1:0]       stale_o,
    output logic                       all_new_o,
    output logic [PendW-1:0]           num_pending_o
);

    group_status_t        st [NumGroups];
    logic [NumGroups-1:0] pending;

    for (genvar g = 0; g < NumGroups; g++) begin : g_grp
        aes_reg_status_group #(
            .Width        (Width),
            .TimeoutCycles(TimeoutCycles),
            .AutoArm      (AutoArm)
        ) u_grp (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .we_i       (we_i[g*Width +: Width]),
            .use_i      (use_i[g]),
            .clear_i    (clear_i[g]),
            .arm_i      (arm_i[g]),
            .status_o   (st[g]),
            .new_pulse_o(new_pulse_o[g])
        );
        assign new_o[g]   = st[g].is_new;
        assign clean_o[g] = st[g].clean;
        assign stale_o[g] = st[g].stale;
    end

    // aggregates derived purely from the registered per-group flags
    always_comb begin
        pending       = ~new_o;
        all_new_o     = &new_o;
        num_pending_o = PendW'(popcount(32'(pending)));
    end

endmodule

// File: tb/tb_aes_reg_status_multi.sv
// tb_aes_reg_status_multi: directed + random checks of two tracker instances (AutoArm off/on) against a set-of-written-words model
module tb_aes_reg_status_multi;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [11:0] we_i = '0;
    logic [2:0]  use_i = '0, clear_i = '0, arm_i = '0;
    logic [2:0]  new_o[2], pulse_o[2], clean_o[2], stale_o[2];
    logic        all_new_o[2];
    logic [1:0]  pend_o[2];

    int n_tests = 0, n_fail = 0;

    // model: which words of each group have been written, plus flags and idle time since last write
    int mm[2][3], mi[2][3], nm[2][3], ni[2][3];
    bit ma[2][3], mn[2][3], mc[2][3], na[2][3], nn[2][3], nc[2][3];

    always #5 clk = ~clk;

    aes_reg_status_multi #(.AutoArm(1'b0)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .we_i(we_i), .use_i(use_i), .clear_i(clear_i), .arm_i(arm_i),
        .new_o(new_o[0]), .new_pulse_o(pulse_o[0]), .clean_o(clean_o[0]), .stale_o(stale_o[0]),
        .all_new_o(all_new_o[0]), .num_pending_o(pend_o[0])
    );

    aes_reg_status_multi #(.AutoArm(1'b1)) u_dut_aa (
        .clk_i(clk), .rst_i(rst_i), .we_i(we_i), .use_i(use_i), .clear_i(clear_i), .arm_i(arm_i),
        .new_o(new_o[1]), .new_pulse_o(pulse_o[1]), .clean_o(clean_o[1]), .stale_o(stale_o[1]),
        .all_new_o(all_new_o[1]), .num_pending_o(pend_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 2; a++)
            for (int g = 0; g < 3; g++) begin
                mm[a][g] = 0; mi[a][g] = 0; ma[a][g] = 0; mn[a][g] = 0; mc[a][g] = 0;
            end
    endtask

    task automatic model_next();
        for (int a = 0; a < 2; a++)
            for (int g = 0; g < 3; g++) begin
                int w;
                w = int'(we_i[g*4 +: 4]);
                nm[a][g] = mm[a][g]; na[a][g] = ma[a][g]; nc[a][g] = mc[a][g]; ni[a][g] = mi[a][g];
                if (clear_i[g]) begin
                    nm[a][g] = 0; na[a][g] = 0; nn[a][g] = 0; nc[a][g] = 0; ni[a][g] = 0;
                end else if (use_i[g]) begin
                    nm[a][g] = 0; na[a][g] = (a == 1); nn[a][g] = 0; ni[a][g] = 0;
                end else begin
                    if (w != 0 && ma[a][g]) begin
                        nm[a][g] = w; na[a][g] = 0;
                    end else begin
                        nm[a][g] = mm[a][g] | w; na[a][g] = ma[a][g] | arm_i[g];
                    end
                    nn[a][g] = (nm[a][g] == 15);
                    if (nm[a][g] == 15) nc[a][g] = 1;
                    else if (nm[a][g] != 0) nc[a][g] = 0;
                    ni[a][g] = (w != 0) ? 0 : mi[a][g] + 1;
                end
            end
    endtask

    task automatic check_pulses();
        for (int a = 0; a < 2; a++) begin
            logic [2:0] e;
            for (int g = 0; g < 3; g++) e[g] = nn[a][g] & ~mn[a][g];
            chk($sformatf("pulse[%0d]", a), 32'(pulse_o[a]), 32'(e));
        end
    endtask

    task automatic check_state();
        for (int a = 0; a < 2; a++) begin
            logic [2:0] en, ec, es;
            int pend;
            pend = 0;
            for (int g = 0; g < 3; g++) begin
                en[g] = mn[a][g];
                ec[g] = mc[a][g];
                es[g] = (mm[a][g] != 0) && (mm[a][g] != 15) && (mi[a][g] >= 16);
                if (!mn[a][g]) pend++;
            end
            chk($sformatf("new[%0d]", a), 32'(new_o[a]), 32'(en));
            chk($sformatf("clean[%0d]", a), 32'(clean_o[a]), 32'(ec));
            chk($sformatf("stale[%0d]", a), 32'(stale_o[a]), 32'(es));
            chk($sformatf("all_new[%0d]", a), 32'(all_new_o[a]), 32'(pend == 0));
            chk($sformatf("pending[%0d]", a), 32'(pend_o[a]), 32'(pend));
        end
    endtask

    task automatic cycle(input logic [11:0] we, input logic [2:0] us, input logic [2:0] cl, input logic [2:0] ar);
        @(negedge clk);
        we_i = we; use_i = us; clear_i = cl; arm_i = ar;
        #1;
        model_next();
        check_pulses();
        @(posedge clk);
        mm = nm; mi = ni; ma = na; mn = nn; mc = nc;
        #1;
        check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0, '0);
    endtask

    initial begin
        model_reset();
        #2;
        check_state();
        @(negedge clk);
        rst_i = 1'b0;

        // group0 filled over two cycles
        cycle(12'h003, 0, 0, 0);
        cycle(12'h00C, 0, 0, 0);
        chk("first_new", 32'(new_o[0]), 32'h1);
        chk("first_pend", 32'(pend_o[0]), 32'h2);

        // armed restart with a single word drops new/clean
        cycle(12'h000, 0, 0, 3'b001);
        cycle(12'h002, 0, 0, 0);
        chk("armed_new", 32'(new_o[0][0]), 32'h0);
        chk("armed_clean", 32'(clean_o[0][0]), 32'h0);

        // group1 watchdog: stale exactly 16 idle cycles after a partial write
        cycle(12'h010, 0, 0, 0);
        idle(15);
        chk("stale_early", 32'(stale_o[0][1]), 32'h0);
        idle(1);
        chk("stale_hit", 32'(stale_o[0][1]), 32'h1);
        cycle(12'h020, 0, 0, 0);
        chk("stale_drop", 32'(stale_o[0][1]), 32'h0);

        // complete everything, then consume group1
        cycle(12'hFCD, 0, 0, 0);
        chk("all_new", 32'(all_new_o[0]), 32'h1);
        cycle(12'h000, 3'b010, 0, 0);
        chk("use_new", 32'(new_o[0]), 32'h5);
        chk("use_pend", 32'(pend_o[0]), 32'h1);

        // re-arm on use, then a single word starts fresh
        cycle(12'h000, 3'b100, 0, 0);
        cycle(12'h800, 0, 0, 0);
        cycle(12'h700, 0, 0, 0);

        // partial group0, stale group1, then asynchronous reset between edges
        cycle(12'h000, 0, 3'b111, 0);
        cycle(12'h011, 0, 0, 0);
        idle(17);
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        chk("async_new", 32'(new_o[0]), 32'h0);
        chk("async_stale", 32'(stale_o[0]), 32'h0);
        chk("async_pend", 32'(pend_o[0]), 32'h3);
        check_state();
        @(negedge clk);
        rst_i = 1'b0;

        // clear and use together on a complete group
        cycle(12'h00F, 0, 0, 0);
        cycle(12'h000, 3'b001, 3'b001, 0);
        chk("clruse_new", 32'(new_o[0][0]), 32'h0);
        chk("clruse_clean", 32'(clean_o[0][0]), 32'h0);

        // random traffic with occasional long idle stretches
        for (int i = 0; i < 400; i++) begin
            logic [11:0] we;
            logic [2:0] us, cl, ar;
            we = '0;
            for (int b = 0; b < 12; b++) we[b] = ($urandom_range(0, 5) == 0);
            us = '0; cl = '0; ar = '0;
            for (int g = 0; g < 3; g++) begin
                us[g] = ($urandom_range(0, 11) == 0);
                cl[g] = ($urandom_range(0, 19) == 0);
                ar[g] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 3) == 0) we = '0;
            cycle(we, us, cl, ar);
            if ($urandom_range(0, 24) == 0) idle(18);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
